// File: rtl/uart_pkg.sv
// Shared types and constants for the board UART transmit path.
// Imported by the scheduler and the frame shifter.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_MON = 1'b1;

    localparam int UART_FRAME_BITS = 10;

endpackage

// File: rtl/uart_tx_shifter.sv
// Frame sequencer: start bit, 8 data bits LSB-first, stop bit.
// Bit timing restarts from the load cycle, so there is no free-running tick.
module uart_tx_shifter
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = 219,
    parameter int DIV_W    = 12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] data,
    output logic       tx,
    output logic       busy
);

    localparam logic [DIV_W-1:0] RELOAD = DIV_W'(BAUD_DIV - 1);

    state_t           state;
    state_t           state_next;
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] cnt_next;
    logic [2:0]       bit_idx;
    logic [2:0]       bit_next;
    logic [7:0]       shift;
    logic [7:0]       shift_next;
    logic             tx_next;
    logic             tick;

    assign tick = (cnt == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
            tx      <= 1'b1;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            bit_idx <= bit_next;
            shift   <= shift_next;
            tx      <= tx_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        bit_next   = bit_idx;
        shift_next = shift;
        unique case (state)
            IDLE: begin
                if (load) begin
                    state_next = START;
                    cnt_next   = RELOAD;
                    shift_next = data;
                end
            end
            START: begin
                if (tick) begin
                    state_next = DATA;
                    bit_next   = '0;
                    cnt_next   = RELOAD;
                end else begin
                    cnt_next = cnt - DIV_W'(1);
                end
            end
            DATA: begin
                if (tick) begin
                    shift_next = shift >> 1;
                    cnt_next   = RELOAD;
                    if (bit_idx == 3'd7) begin
                        state_next = STOP;
                    end else begin
                        bit_next = bit_idx + 3'd1;
                    end
                end else begin
                    cnt_next = cnt - DIV_W'(1);
                end
            end
            STOP: begin
                if (tick) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt - DIV_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Line level follows the next state so tx is a clean flop output.
    always_comb begin
        tx_next = 1'b1;
        unique case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift_next[0];
            default: tx_next = 1'b1;
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin arbiter between CPU and monitor byte producers
// feeding a single UART transmit shifter.
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = 219,
    parameter int DIV_W    = 12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       cpu_valid,
    input  logic [7:0] cpu_data,
    output logic       cpu_ready,
    input  logic       mon_valid,
    input  logic [7:0] mon_data,
    output logic       mon_ready,
    output logic       tx,
    output logic       busy
);

    // Requester that wins the next tie.
    logic       prio;
    logic       cpu_win;
    logic       mon_win;
    logic       load;
    logic [7:0] load_data;

    always_comb begin
        cpu_win = 1'b0;
        mon_win = 1'b0;
        if (!rst && en && !busy) begin
            if (cpu_valid && (!mon_valid || prio == REQ_CPU)) begin
                cpu_win = 1'b1;
            end else if (mon_valid) begin
                mon_win = 1'b1;
            end
        end
    end

    assign cpu_ready = cpu_win;
    assign mon_ready = mon_win;
    assign load      = cpu_win | mon_win;
    assign load_data = mon_win ? mon_data : cpu_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio <= REQ_CPU;
        end else if (cpu_win) begin
            prio <= REQ_MON;
        end else if (mon_win) begin
            prio <= REQ_CPU;
        end
    end

    uart_tx_shifter #(
        .BAUD_DIV(BAUD_DIV),
        .DIV_W   (DIV_W)
    ) u_shifter (
        .clk (clk),
        .rst (rst),
        .load(load),
        .data(load_data),
        .tx  (tx),
        .busy(busy)
    );

endmodule

// File: tb/tb_uart_tx_sched.sv
// Scoreboard bench for uart_tx_sched: transaction-level arbiter model
// predicts grants, a line monitor decodes frames off tx.
module tb_uart_tx_sched;

    localparam int D = 219;

    typedef struct {
        logic [7:0] b;
        int         hs;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en = 1'b1;
    logic cv = 1'b0;
    logic mv = 1'b0;
    logic [7:0] cd = 8'h00;
    logic [7:0] md = 8'h00;
    logic cpu_ready, mon_ready, tx, busy;

    logic cv2 = 1'b0;
    logic [7:0] cd2 = 8'h00;
    logic rdy2, mrdy2, tx2, busy2;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    exp_t sb[$];
    logic [7:0] cpu_q[$];
    logic [7:0] mon_q[$];

    bit rand_mode = 0;
    bit en_req = 1;
    bit rst_req = 1;
    bit drop_c = 0;
    bit drop_m = 0;
    bit prio_cpu = 1;
    bit mon_busy = 0;
    int line_free = 0;
    int last_hs = -1000000;

    uart_tx_sched #(.BAUD_DIV(D), .DIV_W(12)) dut (
        .clk(clk), .rst(rst), .en(en),
        .cpu_valid(cv), .cpu_data(cd), .cpu_ready(cpu_ready),
        .mon_valid(mv), .mon_data(md), .mon_ready(mon_ready),
        .tx(tx), .busy(busy)
    );

    uart_tx_sched #(.BAUD_DIV(2), .DIV_W(12)) dut2 (
        .clk(clk), .rst(rst), .en(1'b1),
        .cpu_valid(cv2), .cpu_data(cd2), .cpu_ready(rdy2),
        .mon_valid(1'b0), .mon_data(8'h00), .mon_ready(mrdy2),
        .tx(tx2), .busy(busy2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // One clock: apply inputs after the edge, predict and check mid-cycle.
    task automatic step();
        bit ec, em;
        @(posedge clk);
        #1;
        rst = rst_req;
        en = en_req;
        if (drop_c) begin cv = 0; cd = 8'($urandom); drop_c = 0; end
        if (drop_m) begin mv = 0; md = 8'($urandom); drop_m = 0; end
        if (!cv && cpu_q.size() > 0 && (!rand_mode || $urandom_range(0, 3) == 0)) begin
            cv = 1;
            cd = cpu_q.pop_front();
        end
        if (!mv && mon_q.size() > 0 && (!rand_mode || $urandom_range(0, 3) == 0)) begin
            mv = 1;
            md = mon_q.pop_front();
        end
        @(negedge clk);
        ec = 0;
        em = 0;
        if (!rst && en && cyc >= line_free) begin
            if (cv && (!mv || prio_cpu)) ec = 1;
            else if (mv) em = 1;
        end
        chk("cpu_ready", cpu_ready, ec);
        chk("mon_ready", mon_ready, em);
        chk("busy", busy, !rst && cyc > last_hs && cyc <= last_hs + 10 * D);
        if (rst || cyc > last_hs + 10 * D) chk("tx_idle", tx, 1);
        if (ec || em) begin
            sb.push_back('{ec ? cd : md, cyc});
            last_hs = cyc;
            line_free = cyc + 10 * D + 1;
            prio_cpu = em;
            drop_c = ec;
            drop_m = em;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((cpu_q.size() > 0 || mon_q.size() > 0 || cv || mv ||
                sb.size() > 0 || mon_busy) && n < 40000) begin
            step();
            n++;
        end
        if (n >= 40000) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: %0d frames still pending", sb.size());
        end
        repeat (3) step();
    endtask

    task automatic wait_hs();
        int mark, n;
        mark = last_hs;
        n = 0;
        while (last_hs == mark && n < 5000) begin
            step();
            n++;
        end
        chk("grant_seen", last_hs != mark, 1);
    endtask

    // Line monitor: decode each frame and compare against the scoreboard.
    initial begin
        exp_t e;
        logic [9:0] fr;
        logic got;
        bit ab;
        forever begin
            @(negedge clk);
            if (rst || tx !== 1'b0) continue;
            mon_busy = 1;
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL spurious_start: tx low at cyc %0d, none expected", cyc);
                repeat (10 * D) @(negedge clk);
                mon_busy = 0;
                continue;
            end
            e = sb.pop_front();
            chk("start_cycle", cyc, e.hs + 1);
            fr = {1'b1, e.b, 1'b0};
            ab = 0;
            for (int i = 0; i < 10 && !ab; i++) begin
                got = fr[i];
                for (int k = 0; k < D; k++) begin
                    if (i != 0 || k != 0) @(negedge clk);
                    if (rst) begin
                        ab = 1;
                        break;
                    end
                    if (tx !== fr[i]) got = tx;
                end
                if (!ab) chk($sformatf("frame_%02h_bit%0d", e.b, i), got, fr[i]);
            end
            mon_busy = 0;
        end
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int steps;
        // Reset state, with requests pending to prove readys are gated.
        cv = 1;
        mv = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_tx", tx, 1);
        chk("rst_busy", busy, 0);
        chk("rst_cpu_ready", cpu_ready, 0);
        chk("rst_mon_ready", mon_ready, 0);
        chk("rst_tx2", tx2, 1);
        cv = 0;
        mv = 0;
        rst_req = 0;
        step();

        // Simultaneous pair right after reset: CPU first.
        cpu_q.push_back(8'h0D);
        mon_q.push_back(8'h0A);
        drain();

        // Lone CPU byte, then a tie which now favours the monitor.
        cpu_q.push_back(8'h23);
        drain();
        cpu_q.push_back(8'h11);
        mon_q.push_back(8'h22);
        drain();

        // Monitor streaming: back-to-back frames.
        repeat (3) mon_q.push_back(8'h60);
        drain();

        // en low blocks grants; en dropped mid-frame lets it finish.
        en_req = 0;
        cpu_q.push_back(8'h41);
        mon_q.push_back(8'h42);
        repeat (300) step();
        en_req = 1;
        wait_hs();
        repeat (500) step();
        en_req = 0;
        repeat (10 * D + 300) step();
        en_req = 1;
        drain();

        // Random traffic with en toggling.
        rand_mode = 1;
        for (int r = 0; r < 4; r++) begin
            if ($urandom_range(0, 1) == 1) cpu_q.push_back(8'($urandom));
            if ($urandom_range(0, 1) == 1) mon_q.push_back(8'($urandom));
            steps = $urandom_range(200, 2500);
            en_req = ($urandom_range(0, 3) != 0);
            repeat (steps) step();
        end
        en_req = 1;
        drain();
        rand_mode = 0;

        // Reset during data bit 3 of $23.
        cpu_q.push_back(8'h23);
        wait_hs();
        repeat (4 * D + D / 2) step();
        #2;
        rst = 1;
        rst_req = 1;
        #1;
        chk("abort_tx", tx, 1);
        chk("abort_busy", busy, 0);
        prio_cpu = 1;
        line_free = 0;
        last_hs = -1000000;
        repeat (3) step();
        rst_req = 0;
        cpu_q.push_back(8'h31);
        mon_q.push_back(8'h32);
        drain();

        // Two-cycle bit period build: $FF frame is 20 cycles.
        @(posedge clk);
        #1;
        cv2 = 1;
        cd2 = 8'hFF;
        @(negedge clk);
        chk("b2_ready", rdy2, 1);
        chk("b2_mon_ready", mrdy2, 0);
        @(posedge clk);
        #1;
        cv2 = 0;
        cd2 = 8'h00;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk($sformatf("b2_tx%0d", i), tx2, (i < 2) ? 0 : 1);
            chk($sformatf("b2_busy%0d", i), busy2, 1);
        end
        @(negedge clk);
        chk("b2_busy_end", busy2, 0);
        chk("b2_tx_end", tx2, 1);

        chk("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
